rv32i_multicycle_ctrl: RTL and testbench
========================================

Name: rv32i_multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences one shared memory port, the PC, the instruction register, the ALU, the immediate path and the register file through fetch/decode/execute/memory/writeback.
- Supports opcodes LOAD, OP-IMM, STORE, BRANCH and OP (R-type); everything else halts as illegal.
- The immediate is produced externally from the IR opcode; this block only steers operands and write enables.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request may wait for mem_ready before bus error (>=2).
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
instr  in  32  IR contents, valid from DECODE onward.
alu_zero  in  1  ALU result == 0 (SUB of rs1, rs2).
alu_lt  in  1  signed rs1 < rs2.
alu_ltu  in  1  unsigned rs1 < rs2.
mem_ready  in  1  memory completes the current request this cycle.
mem_req  out  1  memory request, held until mem_ready.
mem_we  out  1  request is a write (store).
addr_sel  out  1  0 = PC, 1 = ALU result drives memory address.
ir_we  out  1  load IR from memory read data.
pc_we  out  1  update PC this cycle.
pc_src  out  1  0 = PC+4, 1 = PC+imm.
alu_src_b  out  1  0 = rs2, 1 = immediate.
alu_op  out  4  ALU operation (package encoding).
result_sel  out  1  0 = ALU, 1 = memory read data to register file.
rf_we  out  1  register file write enable.
retire  out  1  one-cycle pulse per completed instruction.
instret  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W.
illegal  out  1  sticky: halted on unsupported opcode/funct3.
bus_error  out  1  sticky: halted on memory timeout.
state_dbg  out  3  current state encoding.

Behaviour:
- State register, wait counter, instret, illegal and bus_error are flops. All other outputs are combinational from state plus the IR fields and flags.
- Reset (async, any state, including mid-request): state=FETCH, counters=0, illegal=bus_error=0. Every other output is 0 except mem_req=1, which is combinational from FETCH and asserts once reset deasserts.
- FETCH: mem_req=1, mem_we=0, addr_sel=0. On mem_ready: ir_we=1, next DECODE.
- DECODE: one cycle. Opcode not in {0000011, 0010011, 0100011, 1100011, 0110011} -> HALT with illegal=1. A BRANCH with funct3 in {010, 011} -> HALT with illegal=1. Otherwise next EXEC.
- EXEC:
  - OP and OP-IMM: alu_op from funct3. funct7[5] selects SUB/SRA for OP and SRA for OP-IMM funct3=101. alu_src_b=1 for OP-IMM. Next WB.
  - LOAD/STORE: alu_op=ADD, alu_src_b=1, next MEM.
  - BRANCH: alu_op=SUB, alu_src_b=0. Taken = BEQ zero, BNE !zero, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu. Assert pc_we=1, pc_src=taken, retire=1; next FETCH.
- MEM: mem_req=1, addr_sel=1, mem_we=(STORE), ALU operands held as in EXEC. On mem_ready:
  - LOAD -> WB.
  - STORE: pc_we=1, pc_src=0, retire=1, next FETCH.
- WB: rf_we=1, result_sel=(LOAD), pc_we=1, pc_src=0, retire=1, next FETCH. rf_we asserts even for rd=x0; the register file discards it.
- HALT: all enables 0, mem_req=0. Exits only via reset.
- Timeout:
  - The wait counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 and mem_ready=0.
  - When it reaches MEM_TIMEOUT-1 with mem_ready=0, next state is HALT and bus_error=1.
  - mem_ready in that same cycle wins; no error.
- instret increments by 1 in every cycle retire=1.
- Latency: branch 3 cycles, ALU 4, store 4, load 5 (plus memory wait cycles).

Decomposition:
- Package rv32i_ctrl_pkg:
  - ctrl_state_t enum (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7).
  - Opcode constants OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_BRANCH, OPC_OP.
  - alu_op_t: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - funct3 branch constants.
- One sub-module, rv32i_alu_decoder: a combinational map from opcode/funct3/funct7[5] to alu_op. The FSM and the timeout counter stay in the top module.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), mem_ready=1 immediately -> states FETCH, DECODE, EXEC, WB. WB has rf_we=1, result_sel=0, alu_op=ADD, pc_we=1, pc_src=0. retire pulses once; instret=1.
- LW with mem_ready delayed 3 cycles in both FETCH and MEM -> mem_req held, addr_sel=1 in MEM. WB has result_sel=1; 11 cycles total from FETCH entry.
- BEQ with alu_zero=1 -> EXEC pc_src=1, pc_we=1. Repeat with alu_zero=0 -> pc_src=0. BLTU uses alu_ltu, not alu_lt.
- Opcode 0x7F, and a BRANCH with funct3=010 -> HALT after DECODE with illegal=1. No rf_we/pc_we/mem_req thereafter.
- MEM_TIMEOUT=4, mem_ready never asserted -> HALT with bus_error=1 exactly 4 cycles after mem_req rises. Rerun with mem_ready in the 4th cycle -> no error.
- Assert rst_n low mid-MEM of a store -> mem_req/mem_we drop immediately. After release, FETCH with instret=0 and sticky flags clear.

Source files
------------

// File: rtl/rv32i_ctrl_pkg.sv
// Shared types and encodings for the RV32I multi-cycle controller.
package rv32i_ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd7
   } ctrl_state_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_t;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   function automatic logic is_supported_opcode(input logic [6:0] opc);
      return opc inside {OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_BRANCH, OPC_OP};
   endfunction

endpackage

// File: rtl/rv32i_alu_decoder.sv
// Combinational map from opcode/funct3/funct7[5] to the ALU operation.
module rv32i_alu_decoder
   import rv32i_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [3:0] alu_op
);

   // funct7[5] is an immediate bit for most OP-IMM forms, so it only matters for SUB (OP) and SRA/SRAI.
   always_comb begin
      alu_op = ALU_ADD;
      case (opcode)
         OPC_BRANCH: alu_op = ALU_SUB;
         OPC_OP, OPC_OPIMM: begin
            case (funct3)
               3'b000:  alu_op = (opcode == OPC_OP && funct7_5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_op = ALU_SLL;
               3'b010:  alu_op = ALU_SLT;
               3'b011:  alu_op = ALU_SLTU;
               3'b100:  alu_op = ALU_XOR;
               3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_op = ALU_OR;
               default: alu_op = ALU_AND;
            endcase
         end
         default: alu_op = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory timeout detection and retired-instruction counting.
module rv32i_multicycle_ctrl
   import rv32i_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      instr,
   input  logic             alu_zero,
   input  logic             alu_lt,
   input  logic             alu_ltu,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_src,
   output logic             alu_src_b,
   output logic [3:0]       alu_op,
   output logic             result_sel,
   output logic             rf_we,
   output logic             retire,
   output logic [CNT_W-1:0] instret,
   output logic             illegal,
   output logic             bus_error,
   output logic [2:0]       state_dbg
);

   localparam int WCNT_W = $clog2(MEM_TIMEOUT);
   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

   ctrl_state_t       state;
   ctrl_state_t       state_next;
   logic [WCNT_W-1:0] wait_cnt;
   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic              funct7_5;
   logic [3:0]        dec_alu_op;
   logic              taken;
   logic              mem_wait;
   logic              timeout;
   logic              set_illegal;
   logic              set_bus_error;
   logic              unused_instr;

   assign opcode       = instr[6:0];
   assign funct3       = instr[14:12];
   assign funct7_5     = instr[30];
   assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
   assign state_dbg    = state;

   assign mem_wait = (state == FETCH || state == MEM) && !mem_ready;
   assign timeout  = mem_wait && (wait_cnt == WAIT_LAST);

   rv32i_alu_decoder u_alu_decoder (
      .opcode   (opcode),
      .funct3   (funct3),
      .funct7_5 (funct7_5),
      .alu_op   (dec_alu_op)
   );

   always_comb begin
      taken = 1'b0;
      case (funct3)
         F3_BEQ:  taken = alu_zero;
         F3_BNE:  taken = !alu_zero;
         F3_BLT:  taken = alu_lt;
         F3_BGE:  taken = !alu_lt;
         F3_BLTU: taken = alu_ltu;
         F3_BGEU: taken = !alu_ltu;
         default: taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= state_next;
   end

   always_comb begin
      state_next    = state;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      addr_sel      = 1'b0;
      ir_we         = 1'b0;
      pc_we         = 1'b0;
      pc_src        = 1'b0;
      alu_src_b     = 1'b0;
      alu_op        = ALU_ADD;
      result_sel    = 1'b0;
      rf_we         = 1'b0;
      retire        = 1'b0;
      set_illegal   = 1'b0;
      set_bus_error = 1'b0;
      case (state)
         FETCH: begin
            // Gated by rst_n so the request is not raised while reset is held.
            mem_req = rst_n;
            ir_we   = rst_n & mem_ready;
            if (mem_ready)    state_next = DECODE;
            else if (timeout) begin
               state_next    = HALT;
               set_bus_error = 1'b1;
            end
         end
         DECODE: begin
            if (!is_supported_opcode(opcode) ||
                (opcode == OPC_BRANCH && (funct3 == 3'b010 || funct3 == 3'b011))) begin
               state_next  = HALT;
               set_illegal = 1'b1;
            end else begin
               state_next = EXEC;
            end
         end
         EXEC: begin
            alu_op    = dec_alu_op;
            alu_src_b = (opcode != OPC_OP) && (opcode != OPC_BRANCH);
            case (opcode)
               OPC_BRANCH: begin
                  pc_we      = 1'b1;
                  pc_src     = taken;
                  retire     = 1'b1;
                  state_next = FETCH;
               end
               OPC_LOAD, OPC_STORE: state_next = MEM;
               default:             state_next = WB;
            endcase
         end
         MEM: begin
            mem_req   = 1'b1;
            addr_sel  = 1'b1;
            mem_we    = (opcode == OPC_STORE);
            alu_op    = dec_alu_op;
            alu_src_b = 1'b1;
            if (mem_ready) begin
               if (opcode == OPC_STORE) begin
                  pc_we      = 1'b1;
                  retire     = 1'b1;
                  state_next = FETCH;
               end else begin
                  state_next = WB;
               end
            end else if (timeout) begin
               state_next    = HALT;
               set_bus_error = 1'b1;
            end
         end
         WB: begin
            // ALU operands stay steered so the unregistered ALU result is still valid here.
            alu_op     = dec_alu_op;
            alu_src_b  = (opcode != OPC_OP);
            rf_we      = 1'b1;
            result_sel = (opcode == OPC_LOAD);
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_next = FETCH;
         end
         HALT:    state_next = HALT;
         default: state_next = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt  <= '0;
         instret   <= '0;
         illegal   <= 1'b0;
         bus_error <= 1'b0;
      end else begin
         if (state_next != state && (state_next == FETCH || state_next == MEM))
            wait_cnt <= '0;
         else if (mem_wait)
            wait_cnt <= wait_cnt + 1'b1;
         if (retire)        instret   <= instret + 1'b1;
         if (set_illegal)   illegal   <= 1'b1;
         if (set_bus_error) bus_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Table-driven per-cycle checks of the multi-cycle controller plus directed
// sequences for illegal opcodes, memory timeouts and reset in mid-request.
module tb_rv32i_multicycle_ctrl;

   localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd7;
   localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_XOR = 4'd5, A_SRA = 4'd7;

   // exp = {state, mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src_b, alu_op, result_sel, rf_we, retire}
   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [3:0]  flags;
      logic [16:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        alu_zero, alu_lt, alu_ltu, mem_ready;
   logic        mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src_b;
   logic [3:0]  alu_op;
   logic        result_sel, rf_we, retire;
   logic [3:0]  instret;
   logic        illegal, bus_error;
   logic [2:0]  state_dbg;

   int          n_vec = 0;
   int          n_err = 0;
   logic [3:0]  exp_cnt = 4'd0;
   logic        exp_ill = 1'b0;
   logic        exp_be  = 1'b0;
   vec_t        tbl[$];

   always #5 clk = ~clk;

   rv32i_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .instr      (instr),
      .alu_zero   (alu_zero),
      .alu_lt     (alu_lt),
      .alu_ltu    (alu_ltu),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .addr_sel   (addr_sel),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .pc_src     (pc_src),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .result_sel (result_sel),
      .rf_we      (rf_we),
      .retire     (retire),
      .instret    (instret),
      .illegal    (illegal),
      .bus_error  (bus_error),
      .state_dbg  (state_dbg)
   );

   function automatic vec_t mk(input string n, input logic [31:0] i, input logic [3:0] fl,
                               input logic [2:0] st, input logic [6:0] ctl,
                               input logic [3:0] aop, input logic [2:0] wr);
      vec_t v;
      v.name  = n;
      v.instr = i;
      v.flags = fl;
      v.exp   = {st, ctl, aop, wr};
      return v;
   endfunction

   task automatic push(input string n, input logic [31:0] i, input logic [3:0] fl,
                       input logic [2:0] st, input logic [6:0] ctl,
                       input logic [3:0] aop, input logic [2:0] wr);
      tbl.push_back(mk(n, i, fl, st, ctl, aop, wr));
   endtask

   // Fetch, decode and execute of a branch; fl = {zero, lt, ltu, ready}.
   task automatic pushBranch(input string n, input logic [31:0] i, input logic [3:0] fl, input logic tk);
      push({n, "_f"}, i, 4'b0001, S_F, 7'b1001000, A_ADD, 3'b000);
      push({n, "_d"}, i, 4'b0000, S_D, 7'b0000000, A_ADD, 3'b000);
      push({n, "_e"}, i, fl,      S_E, tk ? 7'b0000110 : 7'b0000100, A_SUB, 3'b001);
   endtask

   task automatic applyStimulus(input vec_t v);
      instr = v.instr;
      {alu_zero, alu_lt, alu_ltu, mem_ready} = v.flags;
   endtask

   task automatic checkOutput(input string n, input logic [16:0] e);
      logic [22:0] act;
      logic [22:0] req;
      act = {state_dbg, mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src_b,
             alu_op, result_sel, rf_we, retire, instret, illegal, bus_error};
      req = {e, exp_cnt, exp_ill, exp_be};
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("[TB] FAIL %s: got %h expected %h", n, act, req);
      end
   endtask

   task automatic checkCount(input string n, input logic [3:0] e);
      n_vec++;
      if (instret !== e) begin
         n_err++;
         $display("[TB] FAIL %s: instret got %0d expected %0d", n, instret, e);
      end
   endtask

   // Starts and ends on a falling edge; one vector per clock cycle.
   task automatic runVec(input vec_t v);
      applyStimulus(v);
      #2;
      checkOutput(v.name, v.exp);
      if (v.exp[0]) exp_cnt = exp_cnt + 4'd1;
      @(negedge clk);
   endtask

   task automatic doReset(input string n);
      rst_n   = 1'b0;
      exp_cnt = 4'd0;
      exp_ill = 1'b0;
      exp_be  = 1'b0;
      #1;
      checkOutput(n, {S_F, 7'b0000000, A_ADD, 3'b000});
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      instr = 32'h0;
      {alu_zero, alu_lt, alu_ltu, mem_ready} = 4'b0000;

      // ADD / SUB / XOR / ADDI (imm bit 30 set) / SRAI
      push("add_f", 32'h002081B3, 4'b0001, S_F, 7'b1001000, A_ADD, 3'b000);
      push("add_d", 32'h002081B3, 4'b0000, S_D, 7'b0000000, A_ADD, 3'b000);
      push("add_e", 32'h002081B3, 4'b0000, S_E, 7'b0000000, A_ADD, 3'b000);
      push("add_w", 32'h002081B3, 4'b0000, S_W, 7'b0000100, A_ADD, 3'b011);
      push("sub_f", 32'h402081B3, 4'b0001, S_F, 7'b1001000, A_ADD, 3'b000);
      push("sub_d", 32'h402081B3, 4'b0000, S_D, 7'b0000000, A_ADD, 3'b000);
      push("sub_e", 32'h402081B3, 4'b0000, S_E, 7'b0000000, A_SUB, 3'b000);
      push("sub_w", 32'h402081B3, 4'b0000, S_W, 7'b0000100, A_SUB, 3'b011);
      push("xor_f", 32'h0020C1B3, 4'b0001, S_F, 7'b1001000, A_ADD, 3'b000);
      push("xor_d", 32'h0020C1B3, 4'b0000, S_D, 7'b0000000, A_ADD, 3'b000);
      push("xor_e", 32'h0020C1B3, 4'b0000, S_E, 7'b0000000, A_XOR, 3'b000);
      push("xor_w", 32'h0020C1B3, 4'b0000, S_W, 7'b0000100, A_XOR, 3'b011);
      push("addi_f", 32'hFFF00093, 4'b0001, S_F, 7'b1001000, A_ADD, 3'b000);
      push("addi_d", 32'hFFF00093, 4'b0000, S_D, 7'b0000000, A_ADD, 3'b000);
      push("addi_e", 32'hFFF00093, 4'b0000, S_E, 7'b0000001, A_ADD, 3'b000);
      push("addi_w", 32'hFFF00093, 4'b0000, S_W, 7'b0000101, A_ADD, 3'b011);
      push("srai_f", 32'h4030D293, 4'b0001, S_F, 7'b1001000, A_ADD, 3'b000);
      push("srai_d", 32'h4030D293, 4'b0000, S_D, 7'b0000000, A_ADD, 3'b000);
      push("srai_e", 32'h4030D293, 4'b0000, S_E, 7'b0000001, A_SRA, 3'b000);
      push("srai_w", 32'h4030D293, 4'b0000, S_W, 7'b0000101, A_SRA, 3'b011);
      // LW with three wait cycles in both FETCH and MEM: 11 cycles
      for (int k = 0; k < 3; k++)
         push("lw_f_wait", 32'h0080A283, 4'b0000, S_F, 7'b1000000, A_ADD, 3'b000);
      push("lw_f", 32'h0080A283, 4'b0001, S_F, 7'b1001000, A_ADD, 3'b000);
      push("lw_d", 32'h0080A283, 4'b0000, S_D, 7'b0000000, A_ADD, 3'b000);
      push("lw_e", 32'h0080A283, 4'b0000, S_E, 7'b0000001, A_ADD, 3'b000);
      for (int k = 0; k < 3; k++)
         push("lw_m_wait", 32'h0080A283, 4'b0000, S_M, 7'b1010001, A_ADD, 3'b000);
      push("lw_m", 32'h0080A283, 4'b0001, S_M, 7'b1010001, A_ADD, 3'b000);
      push("lw_w", 32'h0080A283, 4'b0000, S_W, 7'b0000101, A_ADD, 3'b111);
      // SW
      push("sw_f", 32'h0020A223, 4'b0001, S_F, 7'b1001000, A_ADD, 3'b000);
      push("sw_d", 32'h0020A223, 4'b0000, S_D, 7'b0000000, A_ADD, 3'b000);
      push("sw_e", 32'h0020A223, 4'b0000, S_E, 7'b0000001, A_ADD, 3'b000);
      push("sw_m", 32'h0020A223, 4'b0001, S_M, 7'b1110101, A_ADD, 3'b001);
      // Branches; flags = {zero, lt, ltu, ready}
      pushBranch("beq_t",   32'h00208463, 4'b1000, 1'b1);
      pushBranch("beq_nt",  32'h00208463, 4'b0000, 1'b0);
      pushBranch("bltu_nt", 32'h0020E463, 4'b0100, 1'b0);
      pushBranch("bltu_t",  32'h0020E463, 4'b0010, 1'b1);
      pushBranch("bne_t",   32'h00209463, 4'b0000, 1'b1);
      pushBranch("bge_nt",  32'h0020D463, 4'b0100, 1'b0);
      pushBranch("blt_t",   32'h0020C463, 4'b0100, 1'b1);
      pushBranch("bgeu_t",  32'h0020F463, 4'b0000, 1'b1);
      pushBranch("bgeu_nt", 32'h0020F463, 4'b0010, 1'b0);

      @(negedge clk);
      doReset("reset_initial");

      for (int i = 0; i < tbl.size(); i++) runVec(tbl[i]);
      // 16 instructions retired on a 4-bit counter
      checkCount("instret_wrap", 4'd0);

      // Unsupported opcode halts after DECODE
      runVec(mk("ill_f", 32'h0000007F, 4'b0001, S_F, 7'b1001000, A_ADD, 3'b000));
      runVec(mk("ill_d", 32'h0000007F, 4'b0000, S_D, 7'b0000000, A_ADD, 3'b000));
      exp_ill = 1'b1;
      for (int k = 0; k < 3; k++)
         runVec(mk("ill_halt", 32'h0000007F, 4'b1111, S_H, 7'b0000000, A_ADD, 3'b000));
      doReset("reset_after_ill");

      // BRANCH with funct3 = 010
      runVec(mk("brf3_f", 32'h0020A463, 4'b0001, S_F, 7'b1001000, A_ADD, 3'b000));
      runVec(mk("brf3_d", 32'h0020A463, 4'b0000, S_D, 7'b0000000, A_ADD, 3'b000));
      exp_ill = 1'b1;
      for (int k = 0; k < 2; k++)
         runVec(mk("brf3_halt", 32'h0020A463, 4'b0001, S_H, 7'b0000000, A_ADD, 3'b000));
      doReset("reset_after_brf3");

      // mem_ready never arrives: HALT four cycles after mem_req rises
      for (int k = 0; k < 4; k++)
         runVec(mk("to_f_wait", 32'h002081B3, 4'b0000, S_F, 7'b1000000, A_ADD, 3'b000));
      exp_be = 1'b1;
      for (int k = 0; k < 2; k++)
         runVec(mk("to_halt", 32'h002081B3, 4'b0001, S_H, 7'b0000000, A_ADD, 3'b000));
      doReset("reset_after_to");

      // mem_ready in the last allowed cycle: no error
      for (int k = 0; k < 3; k++)
         runVec(mk("edge_f_wait", 32'h002081B3, 4'b0000, S_F, 7'b1000000, A_ADD, 3'b000));
      runVec(mk("edge_f", 32'h002081B3, 4'b0001, S_F, 7'b1001000, A_ADD, 3'b000));
      runVec(mk("edge_d", 32'h002081B3, 4'b0000, S_D, 7'b0000000, A_ADD, 3'b000));
      runVec(mk("edge_e", 32'h002081B3, 4'b0000, S_E, 7'b0000000, A_ADD, 3'b000));
      runVec(mk("edge_w", 32'h002081B3, 4'b0000, S_W, 7'b0000100, A_ADD, 3'b011));

      // Reset asserted while a store waits in MEM
      runVec(mk("rs_f", 32'h0020A223, 4'b0001, S_F, 7'b1001000, A_ADD, 3'b000));
      runVec(mk("rs_d", 32'h0020A223, 4'b0000, S_D, 7'b0000000, A_ADD, 3'b000));
      runVec(mk("rs_e", 32'h0020A223, 4'b0000, S_E, 7'b0000001, A_ADD, 3'b000));
      runVec(mk("rs_m_wait", 32'h0020A223, 4'b0000, S_M, 7'b1110001, A_ADD, 3'b000));
      doReset("reset_mid_store");
      runVec(mk("rs_after_f", 32'h0020A223, 4'b0000, S_F, 7'b1000000, A_ADD, 3'b000));
      runVec(mk("rs_after_f2", 32'h0020A223, 4'b0001, S_F, 7'b1001000, A_ADD, 3'b000));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
